// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit_if
// Description : ID-stage operand, producer-stage and bypass/stall signal
//               bundle between the pipeline and the hazard/forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int AW         = 5,
    parameter int CW         = 16,
    parameter int SW         = $clog2(FWD_STAGES + 2)
);
    logic                       id_valid;
    logic [NUM_SRC*AW-1:0]      id_src_addr;
    logic [NUM_SRC-1:0]         id_src_used;
    logic                       id_wen;
    logic [AW-1:0]              id_waddr;
    logic                       id_md_req;
    logic [FWD_STAGES-1:0]      stage_wen;
    logic [FWD_STAGES*AW-1:0]   stage_waddr;
    logic [FWD_STAGES-1:0]      stage_ready;
    logic                       stall_clr;

    logic [NUM_SRC*SW-1:0]      fwd_sel;
    logic                       stall;
    logic                       md_busy;
    logic                       md_wb_valid;
    logic [AW-1:0]              md_wb_waddr;
    logic [CW-1:0]              stall_cnt;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_wen, id_waddr, id_md_req,
        output stage_wen, stage_waddr, stage_ready, stall_clr,
        input  fwd_sel, stall, md_busy, md_wb_valid, md_wb_waddr, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_wen, id_waddr, id_md_req,
        input  stage_wen, stage_waddr, stage_ready, stall_clr,
        output fwd_sel, stall, md_busy, md_wb_valid, md_wb_waddr, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit
// Description : N-operand / M-stage bypass select, load-use and mul/div
//               scoreboard stall generation, with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int AW         = 5,
    parameter int MD_LAT     = 4,
    parameter int CW         = 16
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    hazard_fwd_unit_if.slave    bus
);
    localparam int               c_SW        = $clog2(FWD_STAGES + 2);
    localparam int               c_CNT_W     = 4;
    localparam logic [c_CNT_W-1:0] c_MD_LAT  = c_CNT_W'(MD_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_SW-1:0]  c_SEL_MD    = c_SW'(FWD_STAGES + 1);
    localparam logic [CW-1:0]    c_STALL_MAX = '1;

    logic                              r_busy;
    logic [c_CNT_W-1:0]                r_cnt;
    logic [AW-1:0]                     r_md_waddr;
    logic [CW-1:0]                     r_stall_cnt;

    logic [NUM_SRC-1:0][FWD_STAGES-1:0] w_hit;
    logic [NUM_SRC-1:0]                w_md_hit;
    logic [NUM_SRC-1:0]                w_sb_hit;
    logic [NUM_SRC*c_SW-1:0]           w_fwd_sel;
    logic                              w_found;
    logic                              w_data_stall;
    logic                              w_md_pending;
    logic                              w_md_last;
    logic                              w_md_waddr_nz;
    logic                              w_waw_stall;
    logic                              w_struct_stall;
    logic                              w_stall;
    logic                              w_issue;

    assign w_md_pending  = r_busy && (r_cnt > c_CNT_ONE);
    assign w_md_last     = r_busy && (r_cnt == c_CNT_ONE);
    assign w_md_waddr_nz = (r_md_waddr != '0);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [AW-1:0] w_src;
        assign w_src = bus.id_src_addr[i*AW +: AW];

        for (genvar k = 0; k < FWD_STAGES; k++) begin : g_stage
            assign w_hit[i][k] = bus.stage_wen[k]
                              && (bus.stage_waddr[k*AW +: AW] != '0)
                              && (bus.stage_waddr[k*AW +: AW] == w_src)
                              && bus.id_src_used[i];
        end

        // The md bus only carries a result in its write-back cycle.
        assign w_md_hit[i] = w_md_last && w_md_waddr_nz && (w_src == r_md_waddr);
        assign w_sb_hit[i] = w_md_pending && w_md_waddr_nz && bus.id_src_used[i]
                          && (w_src == r_md_waddr);
    end

    // Youngest producer wins; only the winner's readiness can stall.
    always_comb begin
        w_fwd_sel    = '0;
        w_data_stall = 1'b0;
        w_found      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_found = 1'b0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                if (w_hit[i][k] && !w_found) begin
                    w_found = 1'b1;
                    w_fwd_sel[i*c_SW +: c_SW] = c_SW'(k + 1);
                    if (!bus.stage_ready[k]) begin
                        w_data_stall = 1'b1;
                    end
                end
            end
            if (!w_found && w_md_hit[i]) begin
                w_fwd_sel[i*c_SW +: c_SW] = c_SEL_MD;
            end
        end
    end

    assign w_waw_stall    = w_md_pending && bus.id_wen && (bus.id_waddr != '0)
                         && (bus.id_waddr == r_md_waddr);
    assign w_struct_stall = w_md_pending && bus.id_md_req;
    assign w_stall        = bus.id_valid
                         && (w_data_stall || (|w_sb_hit) || w_waw_stall || w_struct_stall);
    assign w_issue        = bus.id_valid && bus.id_md_req && !w_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_md_waddr  <= '0;
            r_stall_cnt <= '0;
        end else begin
            // An issue in the write-back cycle reloads instead of retiring.
            if (w_issue) begin
                r_busy     <= 1'b1;
                r_cnt      <= c_MD_LAT;
                r_md_waddr <= bus.id_wen ? bus.id_waddr : '0;
            end else if (r_busy) begin
                r_cnt <= r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    r_busy <= 1'b0;
                end
            end

            if (bus.stall_clr) begin
                r_stall_cnt <= '0;
            end else if (w_stall && (r_stall_cnt != c_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.fwd_sel     = w_fwd_sel;
    assign bus.stall       = w_stall;
    assign bus.md_busy     = r_busy;
    assign bus.md_wb_valid = w_md_last;
    assign bus.md_wb_waddr = r_md_waddr;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_unit
// Description : Directed vector table plus mul/div, reset and counter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;
    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 3;
    localparam int AW         = 5;
    localparam int MD_LAT     = 4;
    localparam int CW         = 10;
    localparam int SW         = 3;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    hazard_fwd_unit_if #(
        .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .AW(AW), .CW(CW), .SW(SW)
    ) bus ();

    hazard_fwd_unit #(
        .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .AW(AW), .MD_LAT(MD_LAT), .CW(CW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                      id_valid;
        logic [NUM_SRC*AW-1:0]     src;
        logic [NUM_SRC-1:0]        used;
        logic [FWD_STAGES-1:0]     wen;
        logic [FWD_STAGES*AW-1:0]  waddr;
        logic [FWD_STAGES-1:0]     ready;
        logic [NUM_SRC*SW-1:0]     exp_sel;
        logic                      exp_stall;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.id_valid    = v.id_valid;
        bus.id_src_addr = v.src;
        bus.id_src_used = v.used;
        bus.stage_wen   = v.wen;
        bus.stage_waddr = v.waddr;
        bus.stage_ready = v.ready;
    endtask

    task automatic idle_ops();
        bus.id_src_addr = '0;
        bus.id_src_used = '0;
        bus.stage_wen   = '0;
        bus.stage_waddr = '0;
        bus.stage_ready = '1;
        bus.id_wen      = 1'b0;
        bus.id_waddr    = '0;
        bus.id_md_req   = 1'b0;
    endtask

    task automatic issue_md(input logic [AW-1:0] wa);
        idle_ops();
        bus.id_valid  = 1'b1;
        bus.id_md_req = 1'b1;
        bus.id_wen    = 1'b1;
        bus.id_waddr  = wa;
        #1;
        chk("issue_no_stall", 32'(bus.stall), 32'd0);
        step();
        bus.id_md_req = 1'b0;
        bus.id_wen    = 1'b0;
        bus.id_waddr  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //           valid src{1,0}        used   wen     waddr{2,1,0}          ready   sel{1,0}          stall
        vecs[0]  = '{1'b1, {5'd0, 5'd5}, 2'b11, 3'b111, {5'd5, 5'd5, 5'd5}, 3'b111, {3'd0, 3'd1}, 1'b0};
        vecs[1]  = '{1'b1, {5'd0, 5'd5}, 2'b11, 3'b110, {5'd5, 5'd5, 5'd5}, 3'b111, {3'd0, 3'd2}, 1'b0};
        vecs[2]  = '{1'b1, {5'd0, 5'd5}, 2'b11, 3'b100, {5'd5, 5'd5, 5'd5}, 3'b111, {3'd0, 3'd3}, 1'b0};
        vecs[3]  = '{1'b1, {5'd0, 5'd5}, 2'b11, 3'b000, {5'd5, 5'd5, 5'd5}, 3'b111, {3'd0, 3'd0}, 1'b0};
        vecs[4]  = '{1'b1, {5'd0, 5'd5}, 2'b10, 3'b111, {5'd5, 5'd5, 5'd5}, 3'b111, {3'd0, 3'd0}, 1'b0};
        vecs[5]  = '{1'b1, {5'd7, 5'd3}, 2'b11, 3'b011, {5'd0, 5'd3, 5'd7}, 3'b110, {3'd1, 3'd2}, 1'b1};
        vecs[6]  = '{1'b1, {5'd7, 5'd3}, 2'b01, 3'b011, {5'd0, 5'd3, 5'd7}, 3'b110, {3'd0, 3'd2}, 1'b0};
        vecs[7]  = '{1'b0, {5'd7, 5'd3}, 2'b11, 3'b011, {5'd0, 5'd3, 5'd7}, 3'b110, {3'd1, 3'd2}, 1'b0};
        vecs[8]  = '{1'b1, {5'd0, 5'd0}, 2'b11, 3'b111, {5'd0, 5'd0, 5'd0}, 3'b000, {3'd0, 3'd0}, 1'b0};
        vecs[9]  = '{1'b1, {5'd0, 5'd6}, 2'b01, 3'b011, {5'd0, 5'd6, 5'd6}, 3'b101, {3'd0, 3'd1}, 1'b0};
        vecs[10] = '{1'b1, {5'd0, 5'd6}, 2'b01, 3'b010, {5'd0, 5'd6, 5'd6}, 3'b101, {3'd0, 3'd2}, 1'b1};
        vecs[11] = '{1'b1, {5'd8, 5'd4}, 2'b11, 3'b101, {5'd8, 5'd0, 5'd4}, 3'b111, {3'd3, 3'd1}, 1'b0};

        resetn        = 1'b0;
        bus.id_valid  = 1'b0;
        bus.stall_clr = 1'b1;
        idle_ops();
        repeat (3) step();
        chk("rst_busy", 32'(bus.md_busy), 32'd0);
        chk("rst_wb_valid", 32'(bus.md_wb_valid), 32'd0);
        chk("rst_wb_waddr", 32'(bus.md_wb_waddr), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        resetn = 1'b1;
        step();

        // Combinational vectors with an idle scoreboard and the counter held clear.
        for (int n = 0; n < 12; n++) begin
            apply(vecs[n]);
            #1;
            chk($sformatf("vec%0d_sel", n), 32'(bus.fwd_sel), 32'(vecs[n].exp_sel));
            chk($sformatf("vec%0d_stall", n), 32'(bus.stall), 32'(vecs[n].exp_stall));
            step();
        end

        // Load-use stall counting.
        bus.stall_clr = 1'b0;
        chk("cnt_cleared", 32'(bus.stall_cnt), 32'd0);
        apply(vecs[5]);
        #1;
        chk("loaduse_stall", 32'(bus.stall), 32'd1);
        step();
        chk("loaduse_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.id_src_used = 2'b01;
        #1;
        chk("loaduse_unused", 32'(bus.stall), 32'd0);
        step();
        chk("loaduse_cnt_hold", 32'(bus.stall_cnt), 32'd1);

        // Single mul/div to r9 with a dependent reader.
        issue_md(5'd9);
        bus.id_src_addr = {5'd0, 5'd9};
        bus.id_src_used = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("md_c%0d_busy", c), 32'(bus.md_busy), 32'd1);
            chk($sformatf("md_c%0d_wb", c), 32'(bus.md_wb_valid), 32'd0);
            chk($sformatf("md_c%0d_stall", c), 32'(bus.stall), 32'd1);
            step();
        end
        #1;
        chk("md_c4_busy", 32'(bus.md_busy), 32'd1);
        chk("md_c4_wb", 32'(bus.md_wb_valid), 32'd1);
        chk("md_c4_waddr", 32'(bus.md_wb_waddr), 32'd9);
        chk("md_c4_stall", 32'(bus.stall), 32'd0);
        chk("md_c4_sel", 32'(bus.fwd_sel), 32'({3'd0, 3'd4}));
        chk("md_c4_cnt", 32'(bus.stall_cnt), 32'd4);
        step();
        #1;
        chk("md_c5_busy", 32'(bus.md_busy), 32'd0);
        chk("md_c5_wb", 32'(bus.md_wb_valid), 32'd0);
        chk("md_c5_sel", 32'(bus.fwd_sel), 32'd0);

        // Structural stall, then back-to-back issue in the write-back cycle.
        issue_md(5'd10);
        bus.id_md_req = 1'b1;
        bus.id_wen    = 1'b1;
        bus.id_waddr  = 5'd11;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("struct_c%0d_stall", c), 32'(bus.stall), 32'd1);
            step();
        end
        #1;
        chk("b2b_stall", 32'(bus.stall), 32'd0);
        chk("b2b_wb", 32'(bus.md_wb_valid), 32'd1);
        chk("b2b_wb_waddr", 32'(bus.md_wb_waddr), 32'd10);
        step();
        bus.id_md_req = 1'b0;
        bus.id_wen    = 1'b0;
        #1;
        chk("reload_busy", 32'(bus.md_busy), 32'd1);
        chk("reload_wb", 32'(bus.md_wb_valid), 32'd0);
        chk("reload_waddr", 32'(bus.md_wb_waddr), 32'd11);
        step();
        // WAW against the outstanding r11 write.
        bus.id_wen   = 1'b1;
        bus.id_waddr = 5'd11;
        #1;
        chk("waw_stall", 32'(bus.stall), 32'd1);
        bus.id_waddr = 5'd0;
        #1;
        chk("waw_r0_stall", 32'(bus.stall), 32'd0);
        bus.id_wen = 1'b0;
        step();
        #1;
        chk("reload_c3_wb", 32'(bus.md_wb_valid), 32'd0);
        step();
        #1;
        chk("reload_c4_wb", 32'(bus.md_wb_valid), 32'd1);
        step();

        // Asynchronous reset with cnt == 2.
        issue_md(5'd12);
        step();
        step();
        #1;
        chk("prerst_busy", 32'(bus.md_busy), 32'd1);
        apply(vecs[5]);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.md_busy), 32'd0);
        chk("arst_wb", 32'(bus.md_wb_valid), 32'd0);
        chk("arst_waddr", 32'(bus.md_wb_waddr), 32'd0);
        chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("arst_stall_follows", 32'(bus.stall), 32'd1);
        step();
        resetn = 1'b1;

        // Saturation: 2^CW stall edges from zero.
        #1;
        for (int c = 0; c < (1 << CW); c++) begin
            step();
        end
        chk("sat_max", 32'(bus.stall_cnt), 32'((1 << CW) - 1));
        step();
        chk("sat_hold", 32'(bus.stall_cnt), 32'((1 << CW) - 1));
        bus.stall_clr = 1'b1;
        step();
        chk("clr_priority", 32'(bus.stall_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
